// File: rtl/alu_result_stage.sv
// Two-entry in-order ALU result buffer between the ALU and register-file writeback.
// Status bits update when a result is accepted. Define ALU_RESULT_DROP_NOWRITE_EN to drop results with reg_write=0.
module alu_result_stage #(
    parameter int RD_W = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      alu_out,
    input  logic            alu_flag,
    input  logic            alu_overflow,
    input  logic            flag_write,
    input  logic            overflow_write,
    input  logic            reg_write,
    input  logic [RD_W-1:0] rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_en,
    output logic            FLAG_Q,
    output logic            OVERFLOW_Q
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]      data;
        logic [RD_W-1:0] rd;
        logic            en;
    } entry_t;

    state_t state_q, state_d;
    logic   in_ready_q;
    logic   flag_q, overflow_q;
    entry_t head_q, tail_q;
    entry_t in_entry;
    logic   accept, enq, pop;

    assign in_entry = '{data: alu_out, rd: rd, en: reg_write};
    assign accept   = in_valid & in_ready_q;
    assign pop      = out_valid & out_ready;

`ifdef ALU_RESULT_DROP_NOWRITE_EN
    assign enq = accept & reg_write;
`else
    assign enq = accept;
`endif

    // State register; in_ready is registered from the next count so out_ready never reaches it combinationally.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        // NOTE: default first so no path through this block leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (enq) state_d = ONE;
            ONE: begin
                if (enq && !pop)      state_d = FULL;
                else if (!enq && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        wb_data   = out_valid ? head_q.data : 8'd0;
        wb_rd     = out_valid ? head_q.rd : '0;
        wb_en     = out_valid ? head_q.en : 1'b0;
    end

    // NOTE: payload storage has no reset; it is only visible through out_valid, which is reset.
    always_ff @(posedge CLK) begin
        unique case (state_q)
            EMPTY: if (enq) head_q <= in_entry;
            ONE: begin
                if (enq && pop)  head_q <= in_entry;
                if (enq && !pop) tail_q <= in_entry;
            end
            FULL:    if (pop) head_q <= tail_q;
            default: ;
        endcase
    end

    // Status bits follow the accept so the next ALU op sees them regardless of writeback stalls.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flag_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            if (flag_write)     flag_q     <= alu_flag;
            if (overflow_write) overflow_q <= alu_overflow;
        end
    end

    assign in_ready   = in_ready_q;
    assign FLAG_Q     = flag_q;
    assign OVERFLOW_Q = overflow_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected entries are queued on accept and compared at the head.
// Honours ALU_RESULT_DROP_NOWRITE_EN the same way the design does.
module tb_alu_result_stage;

    localparam int RD_W = 3;

    typedef struct packed {
        logic [7:0]      data;
        logic [RD_W-1:0] rd;
        logic            en;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            in_valid, in_ready;
    logic [7:0]      alu_out;
    logic            alu_flag, alu_overflow, flag_write, overflow_write, reg_write;
    logic [RD_W-1:0] rd;
    logic            out_valid, out_ready;
    logic [7:0]      wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            wb_en;
    logic            FLAG_Q, OVERFLOW_Q;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   exp_rdy, exp_flag, exp_ovf;
    bit   last_acc;

    alu_result_stage #(.RD_W(RD_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_flag(alu_flag), .alu_overflow(alu_overflow),
        .flag_write(flag_write), .overflow_write(overflow_write),
        .reg_write(reg_write), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
        .FLAG_Q(FLAG_Q), .OVERFLOW_Q(OVERFLOW_Q)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input logic [RD_W-1:0] r,
                         input bit rw, input bit fw, input bit af, input bit ow, input bit ao);
        in_valid = v; alu_out = d; rd = r; reg_write = rw;
        flag_write = fw; alu_flag = af; overflow_write = ow; alu_overflow = ao;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        bit   acc, pop;
        exp_t e;
        @(negedge CLK);
        check("out_valid", out_valid, sb.size() != 0);
        check("in_ready", in_ready, exp_rdy);
        check("flag_q", FLAG_Q, exp_flag);
        check("overflow_q", OVERFLOW_Q, exp_ovf);
        if (sb.size() != 0) begin
            e = sb[0];
            check("wb_data", wb_data, e.data);
            check("wb_rd", wb_rd, e.rd);
            check("wb_en", wb_en, e.en);
        end else begin
            check("wb_idle", {wb_data, wb_rd, wb_en}, 0);
        end
        acc = in_valid && exp_rdy;
        pop = (sb.size() != 0) && out_ready;
        if (pop) void'(sb.pop_front());
        if (acc) begin
            if (flag_write)     exp_flag = alu_flag;
            if (overflow_write) exp_ovf  = alu_overflow;
`ifdef ALU_RESULT_DROP_NOWRITE_EN
            if (reg_write) sb.push_back('{data: alu_out, rd: rd, en: 1'b1});
`else
            sb.push_back('{data: alu_out, rd: rd, en: reg_write});
`endif
        end
        exp_rdy  = sb.size() < 2;
        last_acc = acc;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        exp_rdy = 1'b0; exp_flag = 1'b0; exp_ovf = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic offer_until_taken(input logic [7:0] d, input logic [RD_W-1:0] r);
        drive(1, d, r, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_acc) break;
        end
        check("offer_taken", last_acc, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        out_ready = 1'b0;
        drive(0, 8'h00, '0, 0, 0, 0, 0, 0);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_flags", {FLAG_Q, OVERFLOW_Q}, 0);
        check("rst_wb", {wb_data, wb_rd, wb_en}, 0);
        apply_reset();

        // First edge after release: in_ready still low, an offered entry must be ignored.
        drive(1, 8'hEE, 3'd7, 1, 1, 1, 1, 1);
        step();
        check("no_accept_first_edge", out_valid, 0);

        // Single entry straight through.
        out_ready = 1'b1;
        drive(1, 8'h3C, 3'd2, 1, 0, 0, 0, 0);
        step();
        in_valid = 1'b0;
        check("single_wb_data", wb_data, 8'h3C);
        step();
        step();
        check("single_drained", out_valid, 0);

        // Fill to FULL with writeback stalled; third offer waits.
        out_ready = 1'b0;
        drive(1, 8'h11, 3'd1, 1, 0, 0, 0, 0);
        step();
        drive(1, 8'h22, 3'd2, 1, 0, 0, 0, 0);
        step();
        drive(1, 8'h33, 3'd3, 1, 0, 0, 0, 0);
        step();
        check("full_no_accept", last_acc, 0);
        check("full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        check("full_pop_no_accept", last_acc, 0);
        check("after_full_pop_ready", in_ready, 1);
        step();
        check("reaccept_33", last_acc, 1);
        in_valid = 1'b0;
        repeat (3) step();

        // Status write at accept while writeback is stalled.
        out_ready = 1'b0;
        drive(1, 8'h44, 3'd4, 1, 1, 1, 0, 1);
        step();
        check("flag_set", FLAG_Q, 1);
        check("ovf_unchanged", OVERFLOW_Q, 0);
        drive(1, 8'h55, 3'd5, 1, 0, 0, 1, 1);
        step();
        check("ovf_set", OVERFLOW_Q, 1);
        drive(1, 8'h66, 3'd6, 1, 1, 0, 1, 0);
        repeat (2) step();
        check("no_write_when_full", {FLAG_Q, OVERFLOW_Q}, 2'b11);
        drive(0, 8'h00, 3'd0, 1, 1, 0, 1, 0);
        step();
        check("no_write_without_valid", {FLAG_Q, OVERFLOW_Q}, 2'b11);

        // Reset in the middle of a cycle with two entries buffered.
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_flags", {FLAG_Q, OVERFLOW_Q}, 0);
        check("async_in_ready", in_ready, 0);
        apply_reset();
        out_ready = 1'b1;
        repeat (3) step();
        check("no_stale_after_reset", out_valid, 0);

        // Status-only result with reg_write=0.
        out_ready = 1'b0;
        drive(1, 8'h77, 3'd1, 0, 1, 1, 0, 0);
        step();
        in_valid = 1'b0;
        check("nowrite_flag", FLAG_Q, 1);
`ifdef ALU_RESULT_DROP_NOWRITE_EN
        check("nowrite_dropped", out_valid, 0);
`else
        check("nowrite_queued", {out_valid, wb_en}, 2'b10);
`endif
        out_ready = 1'b1;
        repeat (2) step();
        offer_until_taken(8'h88, 3'd2);
        repeat (2) step();

        // Random traffic with random writeback stalls.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), RD_W'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("final_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: RD_W, 3, destination register index width.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  upstream ALU result present this cycle.
REQ-005 in_ready  out  1  stage can accept a result; registered.
REQ-006 alu_out  in  8  ALU result byte.
REQ-007 alu_flag, alu_overflow  in  1 each  ALU FLAG_OUT / OVERFLOW_OUT.
REQ-008 flag_write, overflow_write  in  1 each  ALU status write enables.
REQ-009 reg_write  in  1  result targets register file.
REQ-010 rd  in  RD_W  destination register index.
REQ-011 out_valid  out  1  head entry valid toward register-file writeback.
REQ-012 out_ready  in  1  writeback consumes head entry.
REQ-013 wb_data  out  8; wb_rd  out  RD_W; wb_en  out  1: head entry fields.
REQ-014 FLAG_Q, OVERFLOW_Q  out  1 each  architectural status bits, fed to ALU FLAG_IN / OVERFLOW_IN.

Function
REQ-015 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-016 Two-entry in-order result buffer, states EMPTY, ONE, FULL (count 0/1/2).
REQ-017 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without pop; ONE->EMPTY on pop without accept; ONE->ONE on accept and pop together; FULL->ONE on pop.
REQ-018 FULL never accepts: in_ready is 0 throughout FULL, even in the cycle a pop occurs.
REQ-019 in_ready is a flop equal to (next count < 2); no combinational path from out_ready to in_ready.
REQ-020 out_valid = count != 0; wb_data/wb_rd/wb_en come from the head entry; when EMPTY, wb_data = 0, wb_rd = 0, wb_en = 0.
REQ-021 Latency: an entry accepted at edge N appears at the outputs after edge N when the buffer was EMPTY; behind one entry it appears after the pop of that entry.
REQ-022 Head outputs stay stable while out_valid & !out_ready.
REQ-023 Accept with flag_write=1 loads FLAG_Q <= alu_flag at that edge; accept with overflow_write=1 loads OVERFLOW_Q <= alu_overflow; both update independently in one cycle.
REQ-024 Status bits update at accept, not at pop, so the next ALU op sees them on the following cycle regardless of writeback stalls.
REQ-025 Write enables without accept (in_valid=0 or in_ready=0) leave FLAG_Q/OVERFLOW_Q unchanged.
REQ-026 Entry payload = {alu_out, rd, reg_write}; accepted results leave in acceptance order with no reordering, loss or duplication.

Reset
REQ-027 RESET high immediately forces count=EMPTY, in_ready=0, out_valid=0, wb_data=0, wb_rd=0, wb_en=0, FLAG_Q=0, OVERFLOW_Q=0.
REQ-028 First rising edge after RESET deasserts sets in_ready=1; no entry is accepted at that edge.
REQ-029 RESET mid-operation discards all buffered entries; none are presented after reset.

Configuration
REQ-030 Macro ALU_RESULT_DROP_NOWRITE_EN.
REQ-031 Defined: an accept with reg_write=0 (compare ops, pure status ops) updates status bits per REQ-023 but does not enqueue; count unchanged by it.
REQ-032 Undefined: every accept enqueues; entries with reg_write=0 present out_valid=1, wb_en=0.

Verification
REQ-033 Reset, then accept alu_out=8'h3C, rd=2, reg_write=1, out_ready=1 -> next cycle out_valid=1, wb_data=8'h3C, wb_rd=2, wb_en=1; following cycle out_valid=0.
REQ-034 out_ready=0, accept 8'h11 then 8'h22 -> FULL, in_ready=0; third offered 8'h33 not taken; release out_ready -> 8'h11, 8'h22, then 8'h33 after re-acceptance.
REQ-035 Accept with flag_write=1, alu_flag=1, overflow_write=0, alu_overflow=1 -> FLAG_Q=1, OVERFLOW_Q=0 next cycle, while out_ready=0 keeps buffer full.
REQ-036 FULL with simultaneous pop and in_valid=1 -> entry not accepted that cycle, state ONE, in_ready=1 next cycle.
REQ-037 Two entries buffered, assert RESET mid-cycle -> out_valid, FLAG_Q, OVERFLOW_Q go 0 without a clock edge; no stale entries after release.
REQ-038 Accept reg_write=0 with alu_flag=1, flag_write=1 -> macro defined: out_valid stays 0, FLAG_Q=1; undefined: out_valid=1, wb_en=0, FLAG_Q=1.
